// File: rtl/gate_bist_ctrl.sv
// BIST harness for a 16-in/10-out combinational gate netlist: LFSR pattern source,
// MISR output compactor and a golden-signature compare at the end of each run.
module gate_bist_ctrl #(
  parameter int unsigned PATTERNS  = 1024,
  parameter int unsigned SETTLE    = 4,
  parameter logic [15:0] LFSR_SEED = 16'h0001,
  parameter logic [9:0]  MISR_SEED = 10'h000,
  parameter logic [9:0]  GOLDEN    = 10'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] dut_in,
  input  logic [9:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [9:0]  signature,
  output logic [15:0] pattern_cnt
);

  localparam int unsigned LW = 16;
  localparam int unsigned MW = 10;
  localparam int unsigned CW = 16;

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [LW-1:0] SEED_EFF    = (LFSR_SEED == '0) ? LW'(1) : LFSR_SEED;
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE - 1);
  localparam logic [CW-1:0] LAST_PAT    = CW'(PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [MW-1:0] misr_q, misr_d, misr_step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] settle_q, settle_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      misr_q   <= MISR_SEED;
      cnt_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    misr_step = {misr_q[8:0], misr_q[9] ^ misr_q[6]} ^ dut_out;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          lfsr_d   = SEED_EFF;
          misr_d   = MISR_SEED;
          cnt_d    = '0;
          settle_d = SETTLE_INIT;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q - CW'(1);
        end
      end
      S_CAPTURE: begin
        // Abort wins over the capture step so the signature stays inspectable.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          misr_d = misr_step;
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_PAT) begin
            state_d = S_DONE;
          end else begin
            settle_d = SETTLE_INIT;
            state_d  = S_APPLY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags follow the next state; misr is frozen in DONE so pass holds.
    busy_d = (state_d == S_APPLY) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (misr_d == GOLDEN);
  end

  assign dut_in      = lfsr_q;
  assign signature   = misr_q;
  assign pattern_cnt = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: run results are queued at start, and a monitor
// compares them when done rises; directed checks cover sequencing, abort and reset.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_m, abort_m, start_s, mode;
  logic [15:0] dut_in_m, cnt_m, dut_in_1, cnt_1, dut_in_2, cnt_2;
  logic [9:0]  dut_out_m, sig_m, sig_1, sig_2;
  logic        busy_m, done_m, pass_m, busy_1, done_1, pass_1, busy_2, done_2, pass_2;

  // Stand-in netlist: constant all-ones or a pattern-dependent mix of inputs.
  assign dut_out_m = mode ? (dut_in_m[9:0] ^ dut_in_m[15:6]) : 10'h3FF;

  gate_bist_ctrl #(.PATTERNS(12), .SETTLE(2), .LFSR_SEED(16'h0001),
                   .MISR_SEED(10'h000), .GOLDEN(10'h15E)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort_m),
    .dut_in(dut_in_m), .dut_out(dut_out_m), .busy(busy_m), .done(done_m),
    .pass(pass_m), .signature(sig_m), .pattern_cnt(cnt_m));

  gate_bist_ctrl #(.PATTERNS(1), .SETTLE(1), .LFSR_SEED(16'h0001),
                   .MISR_SEED(10'h000), .GOLDEN(10'h3FF)) u_t1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
    .dut_in(dut_in_1), .dut_out(10'h3FF), .busy(busy_1), .done(done_1),
    .pass(pass_1), .signature(sig_1), .pattern_cnt(cnt_1));

  gate_bist_ctrl #(.PATTERNS(2), .SETTLE(1), .LFSR_SEED(16'h0001),
                   .MISR_SEED(10'h000), .GOLDEN(10'h001)) u_t2 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
    .dut_in(dut_in_2), .dut_out(10'h3FF), .busy(busy_2), .done(done_2),
    .pass(pass_2), .signature(sig_2), .pattern_cnt(cnt_2));

  typedef struct {
    logic [9:0]  sig;
    logic [15:0] cnt;
    logic        pass;
  } exp_t;

  exp_t q_m[$];
  exp_t q_1[$];
  exp_t q_2[$];
  exp_t e_mon;
  int   checks   = 0;
  int   failures = 0;
  logic pd_m = 1'b0, pd_1 = 1'b0, pd_2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference step functions written as tap-mask parities.
  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic logic [9:0] misr_nx(input logic [9:0] m, input logic [9:0] d);
    return {m[8:0], ^(m & 10'h240)} ^ d;
  endfunction

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] l = 16'h0001;
    for (int i = 0; i < k; i++) l = lfsr_nx(l);
    return l;
  endfunction

  function automatic exp_t model(input logic md, input int n);
    exp_t        r;
    logic [15:0] l = 16'h0001;
    logic [9:0]  m = 10'h000;
    for (int i = 0; i < n; i++) begin
      m = misr_nx(m, md ? (l[9:0] ^ l[15:6]) : 10'h3FF);
      l = lfsr_nx(l);
    end
    r.sig  = m;
    r.cnt  = 16'(n);
    r.pass = (m == 10'h15E);
    return r;
  endfunction

  // Monitor: each rising done is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (done_m && !pd_m) begin
      if (q_m.size() == 0) begin
        checks++; failures++;
        $display("FAIL main_done: got unexpected done expected none (t=%0t)", $time);
      end else begin
        e_mon = q_m.pop_front();
        chk("main_sig", 32'(sig_m), 32'(e_mon.sig));
        chk("main_cnt", 32'(cnt_m), 32'(e_mon.cnt));
        chk("main_pass", 32'(pass_m), 32'(e_mon.pass));
      end
    end
    if (done_1 && !pd_1) begin
      if (q_1.size() == 0) begin
        checks++; failures++;
        $display("FAIL t1_done: got unexpected done expected none (t=%0t)", $time);
      end else begin
        e_mon = q_1.pop_front();
        chk("t1_sig", 32'(sig_1), 32'(e_mon.sig));
        chk("t1_cnt", 32'(cnt_1), 32'(e_mon.cnt));
        chk("t1_pass", 32'(pass_1), 32'(e_mon.pass));
      end
    end
    if (done_2 && !pd_2) begin
      if (q_2.size() == 0) begin
        checks++; failures++;
        $display("FAIL t2_done: got unexpected done expected none (t=%0t)", $time);
      end else begin
        e_mon = q_2.pop_front();
        chk("t2_sig", 32'(sig_2), 32'(e_mon.sig));
        chk("t2_cnt", 32'(cnt_2), 32'(e_mon.cnt));
        chk("t2_pass", 32'(pass_2), 32'(e_mon.pass));
      end
    end
    pd_m = done_m;
    pd_1 = done_1;
    pd_2 = done_2;
  end

  task automatic pulse_start_m();
    @(posedge clk); #1 start_m = 1'b1;
    @(posedge clk); #1 start_m = 1'b0;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_dut_in"}, 32'(dut_in_m), 32'h0001);
    chk({tag, "_sig"}, 32'(sig_m), 32'h000);
    chk({tag, "_cnt"}, 32'(cnt_m), 32'h0);
    chk({tag, "_busy"}, 32'(busy_m), 32'h0);
    chk({tag, "_done"}, 32'(done_m), 32'h0);
    chk({tag, "_pass"}, 32'(pass_m), 32'h0);
  endtask

  exp_t ex;

  initial begin
    rst_n = 1'b0; start_m = 1'b0; abort_m = 1'b0; start_s = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset("reset");
    rst_n = 1'b1;

    // Single- and two-pattern runs with all-ones outputs.
    ex.sig = 10'h3FF; ex.cnt = 16'd1; ex.pass = 1'b1; q_1.push_back(ex);
    ex.sig = 10'h001; ex.cnt = 16'd2; ex.pass = 1'b1; q_2.push_back(ex);
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    chk("t1_busy_c0", 32'(busy_1), 32'h1);
    chk("t2_dut_in_c0", 32'(dut_in_2), 32'h0001);
    @(posedge clk); #1;
    chk("t1_busy_c1", 32'(busy_1), 32'h1);
    @(posedge clk); #1;
    chk("t1_busy_c2", 32'(busy_1), 32'h0);
    chk("t1_done_c2", 32'(done_1), 32'h1);
    chk("t2_dut_in_c2", 32'(dut_in_2), 32'h0002);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_done", 32'(done_2), 32'h1);

    // Full 12-pattern run: each pattern held 3 cycles, done 36 cycles after APPLY entry.
    mode = 1'b0;
    q_m.push_back(model(1'b0, 12));
    pulse_start_m();
    for (int p = 0; p < 12; p++) begin
      for (int s = 0; s < 3; s++) begin
        chk("seq_dut_in", 32'(dut_in_m), 32'(lfsr_at(p)));
        if (s == 0) chk("seq_busy", 32'(busy_m), 32'h1);
        @(posedge clk); #1;
      end
    end
    chk("run_done", 32'(done_m), 32'h1);
    chk("run_busy", 32'(busy_m), 32'h0);
    chk("last_step", 32'(lfsr_at(11)), 32'h0801);
    repeat (3) @(posedge clk);
    #1;
    chk("frozen_sig", 32'(sig_m), 32'(model(1'b0, 12).sig));
    chk("frozen_cnt", 32'(cnt_m), 32'd12);
    chk("held_done", 32'(done_m), 32'h1);

    // Start held high across a run: exactly one run, done drops on APPLY entry.
    q_m.push_back(model(1'b0, 12));
    @(posedge clk); #1 start_m = 1'b1;
    @(posedge clk); #1;
    chk("restart_done_drop", 32'(done_m), 32'h0);
    chk("restart_pass_drop", 32'(pass_m), 32'h0);
    chk("restart_busy", 32'(busy_m), 32'h1);
    repeat (29) @(posedge clk);
    #1 start_m = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held_start_not_done", 32'(done_m), 32'h0);
    @(posedge clk); #1;
    chk("held_start_done", 32'(done_m), 32'h1);
    chk("held_start_cnt", 32'(cnt_m), 32'd12);

    // New start pulse in DONE must reproduce the same signature.
    q_m.push_back(model(1'b0, 12));
    pulse_start_m();
    repeat (36) @(posedge clk);
    #1;
    chk("rerun_done", 32'(done_m), 32'h1);

    // Abort during the capture of pattern 5 with pattern-dependent outputs.
    mode = 1'b1;
    pulse_start_m();
    repeat (14) @(posedge clk);
    #1 abort_m = 1'b1;
    chk("pre_abort_busy", 32'(busy_m), 32'h1);
    @(posedge clk); #1 abort_m = 1'b0;
    chk("abort_busy", 32'(busy_m), 32'h0);
    chk("abort_done", 32'(done_m), 32'h0);
    chk("abort_cnt", 32'(cnt_m), 32'd4);
    chk("abort_sig", 32'(sig_m), 32'(model(1'b1, 4).sig));
    chk("abort_dut_in", 32'(dut_in_m), 32'(lfsr_at(4)));
    repeat (2) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'(busy_m), 32'h0);

    q_m.push_back(model(1'b1, 12));
    pulse_start_m();
    chk("post_abort_seed", 32'(dut_in_m), 32'h0001);
    chk("post_abort_misr", 32'(sig_m), 32'h000);
    repeat (36) @(posedge clk);
    #1;
    chk("post_abort_done", 32'(done_m), 32'h1);

    // Reset in the middle of pattern 3 APPLY.
    mode = 1'b0;
    pulse_start_m();
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_dut_in", 32'(dut_in_m), 32'h0004);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_idle_reset("midrun_reset");
    repeat (40) @(posedge clk);
    #1;
    chk("reset_no_done", 32'(done_m), 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("q_main_empty", 32'(q_m.size()), 32'd0);
    chk("q_t1_empty", 32'(q_1.size()), 32'd0);
    chk("q_t2_empty", 32'(q_2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Built-in self-test harness for the combinational gate-library netlists (16 primary inputs, 10 primary outputs).
- Drives the netlist inputs from a 16-bit LFSR pattern generator and compacts the netlist outputs into a 10-bit MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Sits in the simulator test bay between the control panel and the gate model under test.

Parameters:
- PATTERNS, 1024: number of patterns applied per run; legal range 1..65535.
- SETTLE, 4: cycles each pattern is held before capture, covering netlist settling; must be >= 1.
- LFSR_SEED, 16'h0001: initial LFSR state. A zero value is replaced by 16'h0001.
- MISR_SEED, 10'h000: initial MISR state.
- GOLDEN, 10'h000: expected final signature.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured in IDLE and DONE only.
- abort  in  1  cancels a run in APPLY or CAPTURE.
- dut_in  out  16  pattern driven to netlist inputs N1..N16; bit 0 drives N1.
- dut_out  in  10  netlist outputs, in fixed order as wired by the top level.
- busy  out  1  high in APPLY and CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high: signature == GOLDEN.
- signature  out  10  current MISR contents.
- pattern_cnt  out  16  patterns captured so far in the current run.

Behaviour:
- Reset (rst_n=0 at an edge), from any state including mid-run:
  - state=IDLE; lfsr=LFSR_SEED; misr=MISR_SEED; pattern_cnt=0; settle counter=0.
  - busy=0, done=0, pass=0.
  - dut_in equals lfsr (registered; no combinational path from any input).
- LFSR update:
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Maximal length; never reaches 0 from a nonzero seed.
- MISR update:
  - fb = m[9]^m[6]; next = {m[8:0], fb} ^ dut_out.
- IDLE:
  - start=1: load lfsr=LFSR_SEED, misr=MISR_SEED, pattern_cnt=0, settle counter=SETTLE-1; go to APPLY.
- APPLY:
  - dut_in holds the current pattern.
  - Settle counter decrements each cycle; when it is 0, go to CAPTURE.
  - Each pattern is therefore held exactly SETTLE cycles in APPLY.
- CAPTURE (one cycle):
  - misr updates with dut_out sampled this cycle.
  - lfsr advances; pattern_cnt increments.
  - If the pre-increment pattern_cnt == PATTERNS-1, go to DONE. Otherwise reload the settle counter to SETTLE-1 and go to APPLY.
- Run length:
  - A run occupies PATTERNS*(SETTLE+1) cycles in APPLY/CAPTURE.
  - done rises on the cycle after the last CAPTURE.
- DONE:
  - done=1; pass=(misr==GOLDEN), registered on entry and held.
  - signature and pattern_cnt are frozen.
  - start=1: same action as from IDLE. done and pass drop on the cycle APPLY is entered.
- abort in APPLY or CAPTURE:
  - Next state IDLE; busy=0, done=0, pass=0.
  - lfsr, misr and pattern_cnt keep their last values for inspection.
  - abort has priority over the CAPTURE update in the same cycle (no MISR or LFSR step).
  - abort in IDLE or DONE is ignored.
- start while busy is ignored.
- Simultaneous start and abort in IDLE/DONE: start wins.
- Reset has priority over all other inputs.

Test Plan:
1. PATTERNS=1, SETTLE=1, MISR_SEED=0, dut_out=10'h3FF, start pulse.
   -> dut_in=16'h0001; busy for 2 cycles; done=1; signature=10'h3FF; pattern_cnt=1; pass=1 when GOLDEN=10'h3FF.
2. PATTERNS=2, SETTLE=1, MISR_SEED=0, dut_out=10'h3FF.
   -> dut_in sequence 0001, 0002; signature=10'h001; pass=1 with GOLDEN=10'h001; pass=0 with GOLDEN=10'h000.
3. PATTERNS=12, SETTLE=2, LFSR_SEED=16'h0001.
   -> dut_in steps through 0001, 0002, 0004 … 0400, then 0801; each value held 3 cycles; done exactly 36 cycles after APPLY entry.
4. Abort during the CAPTURE of pattern 5.
   -> IDLE next cycle; pattern_cnt=4; signature unchanged by that cycle; done=0. A following start reloads both seeds and completes normally.
5. rst_n=0 mid-run (pattern 3 in APPLY).
   -> next cycle: IDLE, dut_in=LFSR_SEED, signature=MISR_SEED, pattern_cnt=0, busy=done=pass=0.
6. start held high across a run, then a new start pulse in DONE.
   -> extra starts while busy are ignored (exactly one run); the restart reproduces an identical signature for the same dut_out stimulus.
